observer_stim_seq: RTL and testbench
====================================

# observer_stim_seq

Synchronous stimulus sequencer that sits directly upstream of the observer combinational block and drives its `Enable` and `In0`..`In3` inputs. On a start request it raises `Enable` with all inputs low for one dwell period. It then walks a 4-bit pattern from 0 upward, holding each value for a programmable number of cycles, and reports completion. It replaces hand-timed delay stimulus with a repeatable, clocked source that a downstream sampler can align to through the `Step` strobe.

## Interface
- `DWELL`, default 5: cycles each pattern is held; legal range 1..255.
- `NUM_PATTERNS`, default 16: number of patterns walked, starting at 0; legal range 1..16.
- `Clk`  in  1  single clock; all logic on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  begin a sequence; sampled only in IDLE.
- `Stop`  in  1  abort the sequence; sampled in every state.
- `Hold`  in  1  freeze the dwell countdown while high; outputs unchanged.
- `Enable`  out  1  drives observer `Enable`.
- `In0`, `In1`, `In2`, `In3`  out  1 each  drive observer inputs; `In0` = `Pattern[3]` (MSB), `In3` = `Pattern[0]` (LSB).
- `Pattern`  out  4  current pattern value.
- `Step`  out  1  one-cycle pulse in the first cycle of each new pattern in RUN.
- `Busy`  out  1  high in ARM and RUN.
- `Done`  out  1  one-cycle pulse on normal completion.

## Operation
- States:
  - IDLE: `Enable`=0, `Pattern`=0.
  - ARM: `Enable`=1, `Pattern`=0, held for `DWELL` cycles.
  - RUN: `Enable`=1, `Pattern` advances.
  - DONE: one cycle, `Done`=1, `Enable`=1, `Pattern` holds its last value.
- IDLE→ARM: `Start`=1 and `Stop`=0. The dwell counter loads `DWELL`-1.
- ARM→RUN: dwell count reaches 0 with `Hold`=0. `Pattern` stays 0, `Step` fires, and the counter reloads.
- RUN, count 0, `Hold`=0, `Pattern` < `NUM_PATTERNS`-1: `Pattern` increments by 1, `Step` fires, and the counter reloads.
- RUN, count 0, `Hold`=0, `Pattern` = `NUM_PATTERNS`-1: go to DONE.
- DONE→IDLE unconditionally.
- `Hold`=1 in ARM or RUN: the counter does not decrement and no transition occurs. `Hold` is ignored in IDLE and DONE.
- `Stop`=1 in any non-IDLE state: go to IDLE on the next edge with no `Done` pulse. `Stop` wins over `Hold` and over a simultaneous dwell expiry.
- `Start` outside IDLE is ignored. `Start` and `Stop` together in IDLE: remain in IDLE.
- Counter width is 8 bits. `Pattern` is 4 bits and never wraps; the last value is `NUM_PATTERNS`-1.

## Timing
- Reset values:
  - State = IDLE, counter = 0.
  - `Enable` = `In0`..`In3` = 0, `Pattern` = 0.
  - `Step` = `Busy` = `Done` = 0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `Start` sampled at edge k:
  - `Enable`=1 and `Busy`=1 from cycle k+1.
  - First `Step` at cycle k+1+`DWELL`.
  - Pattern n begins at cycle k+1+`DWELL`·(n+1).
  - `Done` at cycle k+1+`DWELL`·(1+`NUM_PATTERNS`), plus one cycle for every cycle `Hold` was high in ARM/RUN.
- `Busy` falls in the `Done` cycle. `Enable` falls the cycle after `Done`.
- `Reset` mid-sequence: all outputs return to reset values at the next edge and no `Done` is pulsed. `Reset` has priority over every input.
- `DWELL`=1: the pattern changes every cycle and `Step` stays high continuously through RUN.

## Structure
- Package `observer_pkg`:
  - State encoding (IDLE=0, ARM=1, RUN=2, DONE=3), 2 bits.
  - `PATTERN_W`=4 and `DWELL_W`=8 constants.
- Sub-module `stim_dwell_timer`:
  - Inputs: load, hold, load value.
  - Output: expire flag when count = 0 and hold = 0.
  - Reused later by the downstream sampler.
- Top level holds the FSM, the pattern register and the output registers.

## Test plan
- Defaults, `Start` pulse at cycle 10:
  - `Enable` rises at 11.
  - `Step` at 16, 21, … 91 (16 pulses).
  - `Pattern` reads 0..15, with `In3` toggling every 5 cycles.
  - `Done` at 96.
  - `Enable` low at 97.
- Reset behaviour:
  - Assert `Reset` for 2 cycles: every output is 0.
  - `Reset` at pattern 7: next cycle all outputs are 0 and no `Done` ever fires.
- `Hold` high for 3 cycles during pattern 4: pattern 4 lasts 8 cycles and `Done` moves to cycle 99.
- `Stop` in the same cycle as the pattern-9 dwell expiry: returns to IDLE, `Pattern`=0, no `Step`, no `Done`.
- `DWELL`=1, `NUM_PATTERNS`=4, `Start` at 0:
  - ARM at 1.
  - `Step` at 2, 3, 4, 5.
  - `Done` at 6.
- Start/Stop handling:
  - `Start` re-pulsed while `Busy`: ignored, same timeline as the first scenario.
  - `Start` and `Stop` together in IDLE: stays in IDLE.

Source files
------------

// File: rtl/observer_pkg.sv
// observer_pkg: shared state encoding and widths for the observer stimulus path
package observer_pkg;
   localparam int PATTERN_W = 4;
   localparam int DWELL_W = 8;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;
endpackage

// File: rtl/stim_dwell_timer.sv
// stim_dwell_timer: loadable down-counter that flags expiry at zero unless held
module stim_dwell_timer
   import observer_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               hold,
   input  logic [DWELL_W-1:0] load_value,
   output logic               expire
);
   logic [DWELL_W-1:0] count;
   always_ff @(posedge clk) begin
      if (rst) count <= '0;
      else if (load) count <= load_value;
      else if (!hold && count != '0) count <= count - 1'b1;
   end
   assign expire = (count == '0) && !hold;
endmodule

// File: rtl/observer_stim_seq.sv
// observer_stim_seq: arms the observer, then walks a 4-bit pattern with a fixed dwell per value
module observer_stim_seq
   import observer_pkg::*;
#(
   parameter int unsigned DWELL = 5,
   parameter int unsigned NUM_PATTERNS = 16
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic                 Stop,
   input  logic                 Hold,
   output logic                 Enable,
   output logic                 In0,
   output logic                 In1,
   output logic                 In2,
   output logic                 In3,
   output logic [PATTERN_W-1:0] Pattern,
   output logic                 Step,
   output logic                 Busy,
   output logic                 Done
);
   localparam logic [DWELL_W-1:0] RELOAD = DWELL_W'(DWELL - 1);
   localparam logic [PATTERN_W-1:0] LAST = PATTERN_W'(NUM_PATTERNS - 1);
   state_t state, state_nx;
   logic [PATTERN_W-1:0] pattern_nx;
   logic step_nx, load, expire;
   stim_dwell_timer u_timer (
      .clk(Clk),
      .rst(Reset),
      .load(load),
      .hold(Hold),
      .load_value(RELOAD),
      .expire(expire)
   );
   always_comb begin
      state_nx = state;
      pattern_nx = Pattern;
      step_nx = 1'b0;
      load = 1'b0;
      case (state)
         IDLE: if (Start && !Stop) begin
            state_nx = ARM;
            load = 1'b1;
         end
         ARM: if (Stop) state_nx = IDLE;
         else if (expire) begin
            state_nx = RUN;
            step_nx = 1'b1;
            load = 1'b1;
         end
         RUN: if (Stop) state_nx = IDLE;
         else if (expire && Pattern == LAST) state_nx = DONE;
         else if (expire) begin
            pattern_nx = Pattern + 1'b1;
            step_nx = 1'b1;
            load = 1'b1;
         end
         DONE: state_nx = IDLE;
      endcase
      // pattern reads zero whenever the sequencer is idle, including after Stop
      pattern_nx = (state_nx == IDLE) ? '0 : pattern_nx;
   end
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
         Pattern <= '0;
         Step <= 1'b0;
         Enable <= 1'b0;
         Busy <= 1'b0;
         Done <= 1'b0;
      end else begin
         state <= state_nx;
         Pattern <= pattern_nx;
         Step <= step_nx;
         Enable <= state_nx != IDLE;
         Busy <= state_nx == ARM || state_nx == RUN;
         Done <= state_nx == DONE;
      end
   end
   assign {In0, In1, In2, In3} = Pattern;
endmodule

// File: tb/tb_observer_stim_seq.sv
// tb_observer_stim_seq: directed scenarios for the stimulus sequencer, default and DWELL=1 builds
module tb_observer_stim_seq;
   logic clk = 1'b0;
   logic Reset, Start, Stop, Hold;
   logic en0, i00, i01, i02, i03, st0, bu0, dn0;
   logic [3:0] pt0;
   logic en1, i10, i11, i12, i13, st1, bu1, dn1;
   logic [3:0] pt1;
   int vectors = 0;
   int miscompares = 0;
   int steps[$], step_pat[$], steps1[$], step_pat1[$];
   int done_at, done_cnt, en_rise, en_fall, bits_bad, done1, en_rise1;
   logic [11:0] snap;
   logic prev_en, prev_en1;

   always #5 clk = ~clk;

   observer_stim_seq u0 (
      .Clk(clk), .Reset(Reset), .Start(Start), .Stop(Stop), .Hold(Hold),
      .Enable(en0), .In0(i00), .In1(i01), .In2(i02), .In3(i03),
      .Pattern(pt0), .Step(st0), .Busy(bu0), .Done(dn0)
   );

   observer_stim_seq #(.DWELL(1), .NUM_PATTERNS(4)) u1 (
      .Clk(clk), .Reset(Reset), .Start(Start), .Stop(Stop), .Hold(Hold),
      .Enable(en1), .In0(i10), .In1(i11), .In2(i12), .In3(i13),
      .Pattern(pt1), .Step(st1), .Busy(bu1), .Done(dn1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] snap0();
      return {en0, i00, i01, i02, i03, pt0, st0, bu0, dn0};
   endfunction

   // t counts cycles from the scenario start; inputs set in cycle t show at the outputs in t+1
   task automatic run(input int start_c, input int start2_c, input bit both, input int stop_c,
                      input int hold_c, input int hold_n, input int rst_c, input int cap_c);
      steps.delete(); step_pat.delete(); steps1.delete(); step_pat1.delete();
      done_at = -1; done_cnt = 0; en_rise = -1; en_fall = -1; bits_bad = 0;
      done1 = -1; en_rise1 = -1; snap = 'x; prev_en = en0; prev_en1 = en1;
      for (int t = 0; t < 120; t++) begin
         Start = (t == start_c) || (t == start2_c);
         Stop = (t == stop_c) || (both && t == start_c);
         Hold = (t >= hold_c) && (t < hold_c + hold_n);
         Reset = (t == rst_c);
         @(negedge clk);
         if (st0) begin steps.push_back(t); step_pat.push_back(int'(pt0)); end
         if (dn0) begin done_cnt++; if (done_at < 0) done_at = t; end
         if (en0 && !prev_en && en_rise < 0) en_rise = t;
         if (!en0 && prev_en && en_fall < 0) en_fall = t;
         if ({i00, i01, i02, i03} != pt0) bits_bad++;
         if (t == cap_c) snap = snap0();
         if (st1) begin steps1.push_back(t); step_pat1.push_back(int'(pt1)); end
         if (dn1 && done1 < 0) done1 = t;
         if (en1 && !prev_en1 && en_rise1 < 0) en_rise1 = t;
         prev_en = en0;
         prev_en1 = en1;
         @(posedge clk);
         #1;
      end
      Start = 0; Stop = 0; Hold = 0; Reset = 0;
   endtask

   task automatic check_pats(input string tag);
      int bad = 0;
      foreach (step_pat[i]) if (step_pat[i] != i) bad++;
      check(tag, bad, 0);
   endtask

   initial begin
      Reset = 1; Start = 0; Stop = 0; Hold = 0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("reset_outputs", snap0(), 0);
      check("reset_outputs_d1", {en1, i10, i11, i12, i13, pt1, st1, bu1, dn1}, 0);
      @(posedge clk);
      #1 Reset = 0;

      run(10, -1, 0, -1, -1, 0, -1, 96);
      check("def_en_rise", en_rise, 11);
      check("def_step_count", steps.size(), 16);
      check("def_first_step", steps[0], 16);
      check("def_step_5", steps[5], 41);
      check("def_last_step", steps[15], 91);
      check_pats("def_step_pattern");
      check("def_in_bits", bits_bad, 0);
      check("def_done_at", done_at, 96);
      check("def_done_count", done_cnt, 1);
      check("def_done_cycle_outputs", snap, 12'hFF9);
      check("def_en_fall", en_fall, 97);

      run(10, -1, 0, -1, -1, 0, 53, 54);
      check("rst7_outputs", snap, 0);
      check("rst7_step_count", steps.size(), 8);
      check("rst7_done_count", done_cnt, 0);

      run(10, -1, 0, -1, 37, 3, -1, -1);
      check("hold_pat4_len", steps[5] - steps[4], 8);
      check("hold_step_count", steps.size(), 16);
      check("hold_last_step", steps[15], 94);
      check("hold_done_at", done_at, 99);
      check("hold_en_fall", en_fall, 100);

      run(10, -1, 0, 65, -1, 0, -1, 66);
      check("stop9_outputs", snap, 0);
      check("stop9_step_count", steps.size(), 10);
      check("stop9_done_count", done_cnt, 0);
      check("stop9_en_fall", en_fall, 66);

      run(0, -1, 0, -1, -1, 0, -1, -1);
      check("d1_en_rise", en_rise1, 1);
      check("d1_step_count", steps1.size(), 4);
      check("d1_step_first", steps1[0], 2);
      check("d1_step_last", steps1[3], 5);
      check("d1_step_pat_last", step_pat1[3], 3);
      check("d1_done_at", done1, 6);

      run(10, 40, 0, -1, -1, 0, -1, -1);
      check("restart_step_count", steps.size(), 16);
      check("restart_first_step", steps[0], 16);
      check("restart_done_at", done_at, 96);
      check("restart_done_count", done_cnt, 1);

      run(10, -1, 1, -1, -1, 0, -1, 11);
      check("startstop_en_rise", en_rise, -1);
      check("startstop_outputs", snap, 0);
      check("startstop_steps", steps.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
